// File: rtl/nand_seq_pkg.sv
// Shared types, register map, command field positions and timing defaults for the NAND command sequencer.
package nand_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD1,
    ST_ADDR,
    ST_CMD2,
    ST_WAIT_WB,
    ST_WAIT_RB,
    ST_READ,
    ST_DONE
  } state_t;

  // Register byte offsets
  localparam logic [7:0] REG_CMD    = 8'h00;
  localparam logic [7:0] REG_ADDR0  = 8'h04;
  localparam logic [7:0] REG_ADDR1  = 8'h08;
  localparam logic [7:0] REG_STATUS = 8'h0C;

  // CMD register fields
  localparam int unsigned CMD_CMD1_LSB    = 0;
  localparam int unsigned CMD_CMD2_LSB    = 8;
  localparam int unsigned CMD_CMD2_EN_BIT = 16;
  localparam int unsigned CMD_NADDR_LSB   = 17;
  localparam int unsigned CMD_RD_BYTE_BIT = 20;

  // STATUS register fields
  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_DONE_BIT  = 1;
  localparam int unsigned STATUS_RDATA_LSB = 8;

  // Largest address byte count; larger naddr values saturate here
  localparam logic [2:0] NADDR_MAX = 3'd5;

  // Default timing in clocks
  localparam int unsigned T_PULSE_DEF = 3;
  localparam int unsigned T_HOLD_DEF  = 2;
  localparam int unsigned T_WB_DEF    = 8;

  // Latched command descriptor
  typedef struct packed {
    logic       rd_byte;
    logic [2:0] naddr;
    logic       cmd2_en;
    logic [7:0] cmd2;
    logic [7:0] cmd1;
  } cmd_t;

  // Counter width able to hold 0..max(a,b,c)-1
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/nf_strobe_timer.sv
// Byte-slot timer: a start pulse opens a slot with the selected strobe low for T_PULSE
// clocks, then high for T_HOLD clocks; flags the last low clock and the slot end.
module nf_strobe_timer
  import nand_seq_pkg::*;
#(
  parameter int unsigned T_PULSE = T_PULSE_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned CNT_W   = cnt_width(T_PULSE_DEF, T_HOLD_DEF, T_WB_DEF)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic rd,
  output logic we_n,
  output logic re_n,
  output logic last_low_c,
  output logic slot_end_c
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);

  logic             active;
  logic             low;
  logic [CNT_W-1:0] cnt;

  assign last_low_c = active & low & (cnt == PULSE_LAST);
  assign slot_end_c = active & ~low & (cnt == HOLD_LAST);

  // Slot phase counter and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      low    <= 1'b0;
      cnt    <= '0;
      we_n   <= 1'b1;
      re_n   <= 1'b1;
    end else if (start) begin
      active <= 1'b1;
      low    <= 1'b1;
      cnt    <= '0;
      we_n   <= rd;
      re_n   <= ~rd;
    end else if (last_low_c) begin
      low  <= 1'b0;
      cnt  <= '0;
      we_n <= 1'b1;
      re_n <= 1'b1;
    end else if (slot_end_c) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nand_cmd_seq.sv
// APB-programmed NAND command/address/read sequencer with ready/busy wait and done interrupt.
module nand_cmd_seq
  import nand_seq_pkg::*;
#(
  parameter int unsigned T_PULSE = T_PULSE_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned T_WB    = T_WB_DEF
) (
  input  logic        FIC_0_CLK,
  input  logic        FAB_RESET_N,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        NF_CE_N,
  output logic        NF_CLE,
  output logic        NF_ALE,
  output logic        NF_WE_N,
  output logic        NF_RE_N,
  output logic [7:0]  NF_DQ_O,
  output logic        NF_DQ_OE,
  input  logic [7:0]  NF_DQ_I,
  input  logic        NF_RB_N,
  output logic        IRQ
);

  localparam int unsigned CNT_W = cnt_width(T_PULSE, T_HOLD, T_WB);
  localparam logic [CNT_W-1:0] WB_LAST = CNT_W'(T_WB - 1);

  state_t           state, state_next, follow_st;
  cmd_t             cmd_q, cmd_wr;
  logic [31:0]      addr0;
  logic [7:0]       addr1;
  logic             done, done_next, busy_next;
  logic [7:0]       rd_data;
  logic [2:0]       byte_idx, byte_idx_next;
  logic [CNT_W-1:0] wb_cnt, wb_cnt_next;
  logic             rb_meta, rb_sync;
  logic [7:0]       reg_addr;
  logic             wr_acc, rd_setup, wr_setup, start_c, clr_done_c;
  logic             slot_start, slot_rd, last_low_c, slot_end_c;
  logic             we_n_t, re_n_t;
  logic [7:0]       dq_next;
  logic [63:0]      addr_all;
  logic [31:0]      status_val, rd_mux;
  logic             unused_paddr_lsb;

  assign unused_paddr_lsb = ^PADDR[1:0];
  assign PREADY   = 1'b1;
  assign IRQ      = done;
  assign NF_WE_N  = we_n_t;
  assign NF_RE_N  = re_n_t;
  assign reg_addr = {PADDR[7:2], 2'b00};
  assign addr_all = {24'b0, addr1, addr0};

  // APB decode and write-side command descriptor
  always_comb begin
    wr_acc     = PSEL & PENABLE & PWRITE;
    rd_setup   = PSEL & ~PENABLE & ~PWRITE;
    wr_setup   = PSEL & ~PENABLE & PWRITE;
    start_c    = wr_acc & (reg_addr == REG_CMD) & (state == ST_IDLE);
    clr_done_c = wr_acc & (reg_addr == REG_STATUS) & PWDATA[STATUS_DONE_BIT];
    cmd_wr.cmd1    = PWDATA[CMD_CMD1_LSB +: 8];
    cmd_wr.cmd2    = PWDATA[CMD_CMD2_LSB +: 8];
    cmd_wr.cmd2_en = PWDATA[CMD_CMD2_EN_BIT];
    cmd_wr.naddr   = PWDATA[CMD_NADDR_LSB +: 3];
    cmd_wr.rd_byte = PWDATA[CMD_RD_BYTE_BIT];
    if (cmd_wr.naddr > NADDR_MAX) cmd_wr.naddr = NADDR_MAX;
  end

  // State register
  always_ff @(posedge FIC_0_CLK or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) state <= ST_IDLE;
    else              state <= state_next;
  end

  // Next state, slot starts, byte/WB counters and next NAND bus values
  always_comb begin
    state_next    = state;
    slot_start    = 1'b0;
    slot_rd       = 1'b0;
    byte_idx_next = byte_idx;
    wb_cnt_next   = '0;
    dq_next       = 8'h00;
    follow_st     = cmd_q.cmd2_en ? ST_CMD2 : (cmd_q.rd_byte ? ST_WAIT_WB : ST_DONE);
    case (state)
      ST_IDLE: begin
        if (start_c) begin
          state_next = ST_CMD1;
          slot_start = 1'b1;
        end
      end
      ST_CMD1: begin
        if (slot_end_c) begin
          if (cmd_q.naddr != 3'd0) begin
            state_next    = ST_ADDR;
            byte_idx_next = 3'd0;
            slot_start    = 1'b1;
          end else begin
            state_next = follow_st;
            slot_start = cmd_q.cmd2_en;
          end
        end
      end
      ST_ADDR: begin
        if (slot_end_c) begin
          if (byte_idx == cmd_q.naddr - 3'd1) begin
            state_next = follow_st;
            slot_start = cmd_q.cmd2_en;
          end else begin
            byte_idx_next = byte_idx + 3'd1;
            slot_start    = 1'b1;
          end
        end
      end
      ST_CMD2: begin
        if (slot_end_c) state_next = ST_WAIT_WB;
      end
      ST_WAIT_WB: begin
        if (wb_cnt == WB_LAST) state_next = ST_WAIT_RB;
        else                   wb_cnt_next = wb_cnt + CNT_W'(1);
      end
      ST_WAIT_RB: begin
        if (rb_sync) begin
          if (cmd_q.rd_byte) begin
            state_next = ST_READ;
            slot_start = 1'b1;
            slot_rd    = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_READ: begin
        if (slot_end_c) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    case (state_next)
      ST_CMD1: dq_next = start_c ? cmd_wr.cmd1 : cmd_q.cmd1;
      ST_ADDR: dq_next = addr_all[{byte_idx_next, 3'b000} +: 8];
      ST_CMD2: dq_next = cmd_q.cmd2;
      default: dq_next = 8'h00;
    endcase
  end

  // Status view as it will stand during the APB access cycle
  always_comb begin
    busy_next = (state_next != ST_IDLE);
    if (state == ST_DONE) done_next = 1'b1;
    else if (clr_done_c)  done_next = 1'b0;
    else                  done_next = done;
    status_val = '0;
    status_val[STATUS_BUSY_BIT]           = busy_next;
    status_val[STATUS_DONE_BIT]           = done_next;
    status_val[STATUS_RDATA_LSB +: 8]     = rd_data;
    case (reg_addr)
      REG_ADDR0:  rd_mux = addr0;
      REG_ADDR1:  rd_mux = {24'b0, addr1};
      REG_STATUS: rd_mux = status_val;
      default:    rd_mux = '0;
    endcase
  end

  // Configuration, status and counter registers
  always_ff @(posedge FIC_0_CLK or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      cmd_q    <= '0;
      addr0    <= '0;
      addr1    <= '0;
      done     <= 1'b0;
      rd_data  <= '0;
      byte_idx <= '0;
      wb_cnt   <= '0;
    end else begin
      if (start_c) cmd_q <= cmd_wr;
      if (wr_acc && reg_addr == REG_ADDR0) addr0 <= PWDATA;
      if (wr_acc && reg_addr == REG_ADDR1) addr1 <= PWDATA[7:0];
      done     <= done_next;
      byte_idx <= byte_idx_next;
      wb_cnt   <= wb_cnt_next;
      if (state == ST_READ && last_low_c) rd_data <= NF_DQ_I;
    end
  end

  // APB read data and error response, loaded in the setup phase
  always_ff @(posedge FIC_0_CLK or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      PRDATA  <= rd_setup ? rd_mux : 32'h0;
      PSLVERR <= wr_setup & (reg_addr == REG_CMD) & busy_next;
    end
  end

  // Registered NAND bus controls, aligned with the state register
  always_ff @(posedge FIC_0_CLK or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      NF_CE_N  <= 1'b1;
      NF_CLE   <= 1'b0;
      NF_ALE   <= 1'b0;
      NF_DQ_O  <= 8'h00;
      NF_DQ_OE <= 1'b0;
    end else begin
      NF_CE_N  <= (state_next == ST_IDLE) || (state_next == ST_DONE);
      NF_CLE   <= (state_next == ST_CMD1) || (state_next == ST_CMD2);
      NF_ALE   <= (state_next == ST_ADDR);
      NF_DQ_OE <= (state_next == ST_CMD1) || (state_next == ST_CMD2) || (state_next == ST_ADDR);
      NF_DQ_O  <= dq_next;
    end
  end

  // Two-flop synchronizer for the asynchronous ready/busy line
  always_ff @(posedge FIC_0_CLK or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      rb_meta <= 1'b1;
      rb_sync <= 1'b1;
    end else begin
      rb_meta <= NF_RB_N;
      rb_sync <= rb_meta;
    end
  end

  nf_strobe_timer #(
    .T_PULSE (T_PULSE),
    .T_HOLD  (T_HOLD),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk        (FIC_0_CLK),
    .rst_n      (FAB_RESET_N),
    .start      (slot_start),
    .rd         (slot_rd),
    .we_n       (we_n_t),
    .re_n       (re_n_t),
    .last_low_c (last_low_c),
    .slot_end_c (slot_end_c)
  );

endmodule

// File: tb/tb_nand_cmd_seq.sv
// Directed self-checking bench for nand_cmd_seq.
module tb_nand_cmd_seq;

  logic        FIC_0_CLK = 1'b0;
  logic        FAB_RESET_N;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        NF_CE_N, NF_CLE, NF_ALE, NF_WE_N, NF_RE_N, NF_DQ_OE, NF_RB_N, IRQ;
  logic [7:0]  NF_DQ_O, NF_DQ_I;

  int checks   = 0;
  int failures = 0;
  int n_we, n_re, n_cle, n_ale, n_oe, n_ce, irq_idx, re_first;
  logic [7:0] bytes_q[$];
  logic        err;
  logic [31:0] rdat;

  always #5 FIC_0_CLK = ~FIC_0_CLK;

  nand_cmd_seq dut (
    .FIC_0_CLK (FIC_0_CLK), .FAB_RESET_N (FAB_RESET_N),
    .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE), .PADDR (PADDR),
    .PWDATA (PWDATA), .PRDATA (PRDATA), .PREADY (PREADY), .PSLVERR (PSLVERR),
    .NF_CE_N (NF_CE_N), .NF_CLE (NF_CLE), .NF_ALE (NF_ALE), .NF_WE_N (NF_WE_N),
    .NF_RE_N (NF_RE_N), .NF_DQ_O (NF_DQ_O), .NF_DQ_OE (NF_DQ_OE),
    .NF_DQ_I (NF_DQ_I), .NF_RB_N (NF_RB_N), .IRQ (IRQ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
    @(negedge FIC_0_CLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge FIC_0_CLK);
    PENABLE = 1'b1;
    e = PSLVERR;
    @(negedge FIC_0_CLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(negedge FIC_0_CLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge FIC_0_CLK);
    PENABLE = 1'b1;
    d = PRDATA;
    e = PSLVERR;
    @(negedge FIC_0_CLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Observe n cycles of NAND activity starting with the current cycle
  task automatic watch(input int n, input int rb_fall, input int rb_rise);
    logic prev_we;
    n_we = 0; n_re = 0; n_cle = 0; n_ale = 0; n_oe = 0; n_ce = 0;
    irq_idx = -1; re_first = -1; prev_we = 1'b1;
    bytes_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i == rb_fall) NF_RB_N = 1'b0;
      if (i == rb_rise) NF_RB_N = 1'b1;
      if (!NF_WE_N) begin
        n_we++;
        if (prev_we) bytes_q.push_back(NF_DQ_O);
      end
      prev_we = NF_WE_N;
      if (!NF_RE_N) begin
        n_re++;
        if (re_first < 0) re_first = i;
      end
      if (NF_CLE)   n_cle++;
      if (NF_ALE)   n_ale++;
      if (NF_DQ_OE) n_oe++;
      if (!NF_CE_N) n_ce++;
      if (IRQ && irq_idx < 0) irq_idx = i;
      @(negedge FIC_0_CLK);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [47:0] exp, input int cnt);
    logic [47:0] e;
    e = exp;
    check({tag, "_nbytes"}, bytes_q.size(), cnt);
    for (int i = 0; i < cnt && i < bytes_q.size(); i++)
      check({tag, "_byte"}, {24'b0, bytes_q[i]}, {24'b0, e[8*i +: 8]});
  endtask

  initial begin
    FAB_RESET_N = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00; PWDATA = 32'h0;
    NF_DQ_I = 8'h00; NF_RB_N = 1'b1;
    repeat (3) @(negedge FIC_0_CLK);
    FAB_RESET_N = 1'b1;
    @(negedge FIC_0_CLK);

    // Reset state
    check("rst_ce_n", NF_CE_N, 1); check("rst_we_n", NF_WE_N, 1);
    check("rst_re_n", NF_RE_N, 1); check("rst_oe", NF_DQ_OE, 0);
    check("rst_irq", IRQ, 0);      check("rst_pready", PREADY, 1);
    apb_read(8'h0C, rdat, err);    check("rst_status", rdat, 32'h0);

    // Register readback and unmapped access
    apb_write(8'h08, 32'hFFFF_FFAB, err);
    apb_read(8'h08, rdat, err);    check("addr1_rb", rdat, 32'h0000_00AB);
    apb_write(8'h04, 32'h1234_5678, err);
    apb_read(8'h07, rdat, err);    check("addr0_rb_lsb_ignored", rdat, 32'h1234_5678);
    apb_read(8'h10, rdat, err);    check("unmapped_rd", rdat, 32'h0); check("unmapped_rd_err", err, 0);
    apb_write(8'h20, 32'hDEAD_BEEF, err); check("unmapped_wr_err", err, 0);

    // Single command byte
    apb_write(8'h00, 32'h0000_00FF, err);
    check("c1_start_err", err, 0);
    check("c1_cle", NF_CLE, 1); check("c1_dq", NF_DQ_O, 8'hFF); check("c1_oe", NF_DQ_OE, 1);
    watch(12, -1, -1);
    check("c1_we_low", n_we, 3);  check("c1_cle_cyc", n_cle, 5);
    check("c1_ce_cyc", n_ce, 5);  check("c1_irq_idx", irq_idx, 6);
    check("c1_ale_cyc", n_ale, 0);
    check_bytes("c1", 48'h0000_0000_00FF, 1);
    apb_read(8'h0C, rdat, err);   check("c1_status", rdat, 32'h0000_0002);
    apb_write(8'h0C, 32'h2, err);

    // Command + one address byte + read byte
    apb_write(8'h04, 32'h0, err);
    NF_DQ_I = 8'h2C;
    apb_write(8'h00, 32'h0012_0090, err);
    watch(30, -1, -1);
    check_bytes("rd", 48'h0000_0000_0090, 2);
    check("rd_cle_cyc", n_cle, 5); check("rd_ale_cyc", n_ale, 5);
    check("rd_re_low", n_re, 3);   check("rd_re_first", re_first, 19);
    check("rd_oe_cyc", n_oe, 10);  check("rd_ce_cyc", n_ce, 24);
    check("rd_irq_idx", irq_idx, 25);
    apb_read(8'h0C, rdat, err);    check("rd_status", rdat, 32'h0000_2C02);
    apb_write(8'h0C, 32'h2, err);
    NF_DQ_I = 8'h00;

    // Erase: three address bytes, second command, long busy
    apb_write(8'h04, 32'h0003_0201, err);
    apb_write(8'h00, 32'h0007_D060, err);
    watch(110, 0, 100);
    check_bytes("er", 48'h0000_D003_0201 << 8 | 48'h60, 5);
    check("er_we_low", n_we, 15);  check("er_re_low", n_re, 0);
    check("er_ce_cyc", n_ce, 103); check("er_irq_idx", irq_idx, 104);
    apb_read(8'h0C, rdat, err);    check("er_status", rdat, 32'h0000_2C02);
    apb_write(8'h0C, 32'h2, err);

    // naddr=6 saturates to five address bytes
    apb_write(8'h00, 32'h000C_0080, err);
    watch(40, -1, -1);
    check_bytes("sat", 48'hAB00_0302_0180, 6);
    check("sat_ale_cyc", n_ale, 25); check("sat_irq_idx", irq_idx, 31);
    apb_write(8'h0C, 32'h2, err);

    // CMD write while busy is rejected and ignored
    apb_write(8'h00, 32'h0000_00AA, err);
    apb_write(8'h00, 32'h0000_0055, err);
    check("busy_wr_err", err, 1);
    check("busy_dq_kept", NF_DQ_O, 8'hAA); check("busy_cle_kept", NF_CLE, 1);
    watch(10, -1, -1);
    check("busy_we_low", n_we, 0); check("busy_ce_cyc", n_ce, 2);
    check("busy_irq_idx", irq_idx, 3);
    apb_read(8'h0C, rdat, err);    check("busy_status", rdat, 32'h0000_2C02);
    apb_write(8'h0C, 32'h2, err);
    apb_read(8'h0C, rdat, err);    check("clr_status", rdat, 32'h0000_2C00);
    check("clr_irq", IRQ, 0);

    // Done-clear in the same clock as done is set: set wins
    apb_write(8'h00, 32'h0000_00FF, err);
    repeat (3) @(negedge FIC_0_CLK);
    apb_write(8'h0C, 32'h2, err);
    check("setwins_irq", IRQ, 1);

    // Asynchronous reset in the middle of an address slot
    apb_write(8'h00, 32'h0007_D060, err);
    repeat (7) @(negedge FIC_0_CLK);
    check("pre_rst_ale", NF_ALE, 1); check("pre_rst_we_n", NF_WE_N, 0);
    FAB_RESET_N = 1'b0;
    #1;
    check("ar_ce_n", NF_CE_N, 1); check("ar_we_n", NF_WE_N, 1); check("ar_re_n", NF_RE_N, 1);
    check("ar_cle", NF_CLE, 0);   check("ar_ale", NF_ALE, 0);   check("ar_oe", NF_DQ_OE, 0);
    check("ar_dq", NF_DQ_O, 0);   check("ar_irq", IRQ, 0);
    check("ar_prdata", PRDATA, 0); check("ar_pslverr", PSLVERR, 0);
    @(negedge FIC_0_CLK);
    FAB_RESET_N = 1'b1;
    apb_read(8'h0C, rdat, err);   check("ar_status", rdat, 32'h0);
    apb_read(8'h04, rdat, err);   check("ar_addr0", rdat, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
